// File: rtl/noc_config_pkg.sv
// Shared NoC configuration: network-wide parameters and the flit type used by
// every router-side block.
package noc_config_pkg;

  localparam int FLIT_WIDTH = 8;

  typedef logic [FLIT_WIDTH-1:0] noc_flit;

  typedef struct packed {
    logic [7:0] virtual_channels;
    logic [7:0] router_ports;
  } noc_config;

  localparam noc_config NOC_DEFAULT_CONFIG = '{virtual_channels: 8'd2, router_ports: 8'd5};

endpackage

// File: rtl/noc_vc_fifo.sv
// Single-VC circular-buffer FIFO with explicit pointer wrap and a registered
// occupancy count, so DEPTH need not be a power of two.
module noc_vc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CWIDTH = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [WIDTH-1:0]  i_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [CWIDTH-1:0] o_count,
  input  logic              i_pop,
  output logic [WIDTH-1:0]  o_data
);

  localparam int PTRW = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PTRW-1:0]   wrPtr_q, wrPtr_d;
  logic [PTRW-1:0]   rdPtr_q, rdPtr_d;
  logic [CWIDTH-1:0] count_q, count_d;
  logic              push, pop;

  assign o_full  = (count_q == CWIDTH'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_data  = mem[rdPtr_q];

  // Guard against a push into a full buffer or a pop from an empty one.
  assign push = i_push & ~o_full;
  assign pop  = i_pop & ~o_empty;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) begin
      wrPtr_d = (wrPtr_q == PTRW'(DEPTH - 1)) ? '0 : wrPtr_q + PTRW'(1);
    end
    if (pop) begin
      rdPtr_d = (rdPtr_q == PTRW'(DEPTH - 1)) ? '0 : rdPtr_q + PTRW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CWIDTH'(1);
      2'b01:   count_d = count_q - CWIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr_q] <= i_data;
    end
  end

endmodule

// File: rtl/noc_channel_splitter.sv
// Receive side of the per-VC flit link: one-hot check, push/pop decode and one
// independent FIFO per virtual channel so a stalled VC never blocks another.
module noc_channel_splitter
  import noc_config_pkg::*;
#(
  parameter noc_config CONFIG = NOC_DEFAULT_CONFIG,
  parameter int DEPTH = 4,
  localparam int CHANNELS = int'(CONFIG.virtual_channels),
  localparam int CWIDTH = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS-1:0]            i_flit_valid,
  input  noc_flit                        i_flit,
  output logic [CHANNELS-1:0]            o_flit_ready,
  output logic [CHANNELS-1:0]            o_vc_valid,
  output logic [CHANNELS*FLIT_WIDTH-1:0] o_vc_flit,
  input  logic [CHANNELS-1:0]            i_vc_ready,
  output logic [CHANNELS*CWIDTH-1:0]     o_vc_count,
  output logic                           o_protocol_err
);

  logic                oneHot0;
  logic                protocolErr_q, protocolErr_d;
  logic [CHANNELS-1:0] full, empty, push, pop;

  assign oneHot0       = ($countones(i_flit_valid) <= 1);
  assign protocolErr_d = ~oneHot0;
  assign o_protocol_err = protocolErr_q;

  // Ready comes only from registered occupancy (plus reset), keeping the
  // sender free of any combinational loop through valid or consumer ready.
  assign o_flit_ready = ~full & {CHANNELS{~rst}};
  assign o_vc_valid   = ~empty;
  assign push         = i_flit_valid & o_flit_ready & {CHANNELS{oneHot0}};
  assign pop          = o_vc_valid & i_vc_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      protocolErr_q <= 1'b0;
    end else begin
      protocolErr_q <= protocolErr_d;
    end
  end

  for (genvar vc = 0; vc < CHANNELS; vc++) begin : gVc
    noc_vc_fifo #(
      .WIDTH (FLIT_WIDTH),
      .DEPTH (DEPTH)
    ) uFifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (push[vc]),
      .i_data  (i_flit),
      .o_full  (full[vc]),
      .o_empty (empty[vc]),
      .o_count (o_vc_count[vc*CWIDTH +: CWIDTH]),
      .i_pop   (pop[vc]),
      .o_data  (o_vc_flit[vc*FLIT_WIDTH +: FLIT_WIDTH])
    );
  end

endmodule

// File: tb/tb_noc_channel_splitter.sv
// Scoreboard bench for the channel splitter: a per-VC occupancy model predicts
// ready/valid/count, and queued flits are compared as each VC pops its head.
module tb_noc_channel_splitter;
  import noc_config_pkg::*;

  localparam int CH    = 2;
  localparam int DEPTH = 4;
  localparam int FW    = FLIT_WIDTH;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [CH-1:0]    flitValid;
  logic [FW-1:0]    flit;
  logic [CH-1:0]    flitReady;
  logic [CH-1:0]    vcValid;
  logic [CH*FW-1:0] vcFlit;
  logic [CH-1:0]    vcReady;
  logic [CH*CW-1:0] vcCount;
  logic             protocolErr;

  int          checks = 0;
  int          failures = 0;
  int          modelCount [CH];
  logic [FW-1:0] q0 [$];
  logic [FW-1:0] q1 [$];
  logic        expErr;

  always #5 clk = ~clk;

  noc_channel_splitter #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_flit_valid   (flitValid),
    .i_flit         (flit),
    .o_flit_ready   (flitReady),
    .o_vc_valid     (vcValid),
    .o_vc_flit      (vcFlit),
    .i_vc_ready     (vcReady),
    .o_vc_count     (vcCount),
    .o_protocol_err (protocolErr)
  );

  // Compare outputs with the model, score pops against the queues, then
  // advance one clock and check the registered protocol error.
  task automatic clockCycle();
    logic [CH-1:0] push, pop;
    logic          expReady;
    logic [FW-1:0] head;
    int            ones;
    #1;
    ones = $countones(flitValid);
    for (int i = 0; i < CH; i++) begin
      expReady = !rst && (modelCount[i] != DEPTH);
      checks++;
      if (flitReady[i] !== expReady) begin
        failures++;
        $display("[TB] FAIL ready[%0d] got=%0b want=%0b", i, flitReady[i], expReady);
      end
      checks++;
      if (vcValid[i] !== (modelCount[i] != 0)) begin
        failures++;
        $display("[TB] FAIL valid[%0d] got=%0b want=%0b", i, vcValid[i], modelCount[i] != 0);
      end
      checks++;
      if (vcCount[i*CW +: CW] !== CW'(modelCount[i])) begin
        failures++;
        $display("[TB] FAIL count[%0d] got=%0d want=%0d", i, vcCount[i*CW +: CW], modelCount[i]);
      end
      if (modelCount[i] != 0) begin
        head = (i == 0) ? q0[0] : q1[0];
        checks++;
        if (vcFlit[i*FW +: FW] !== head) begin
          failures++;
          $display("[TB] FAIL head[%0d] got=%h want=%h", i, vcFlit[i*FW +: FW], head);
        end
      end
      push[i] = !rst && flitValid[i] && (modelCount[i] != DEPTH) && (ones <= 1);
      pop[i]  = !rst && (modelCount[i] != 0) && vcReady[i];
    end
    if (pop[0])  void'(q0.pop_front());
    if (pop[1])  void'(q1.pop_front());
    if (push[0]) q0.push_back(flit);
    if (push[1]) q1.push_back(flit);
    expErr = !rst && (ones > 1);
    @(posedge clk);
    for (int i = 0; i < CH; i++) begin
      if (rst) modelCount[i] = 0;
      else     modelCount[i] = modelCount[i] + int'(push[i]) - int'(pop[i]);
    end
    if (rst) begin
      q0.delete();
      q1.delete();
    end
    @(negedge clk);
    #1;
    checks++;
    if (protocolErr !== expErr) begin
      failures++;
      $display("[TB] FAIL protocol_err got=%0b want=%0b", protocolErr, expErr);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flitValid = '0;
    flit = '0;
    vcReady = '0;
    modelCount[0] = 0;
    modelCount[1] = 0;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) clockCycle();
    rst = 1'b0;
    #1;
    checks++;
    if (flitReady !== 2'b11) begin
      failures++;
      $display("[TB] FAIL ready_after_reset got=%b want=11", flitReady);
    end
    clockCycle();
  endtask

  task automatic test_fill();
    vcReady = 2'b00;
    for (int k = 0; k < 5; k++) begin
      flitValid = 2'b01;
      flit = FW'(8'hA0 + k);
      clockCycle();
      if (k == 3) begin
        checks++;
        if (flitReady[0] !== 1'b0) begin
          failures++;
          $display("[TB] FAIL fill_ready_drop got=%0b want=0", flitReady[0]);
        end
      end
    end
    vcReady = 2'b01;
    for (int k = 0; k < 2; k++) clockCycle();
    flitValid = 2'b00;
    for (int k = 0; k < 5; k++) clockCycle();
    checks++;
    if (vcCount[0 +: CW] !== CW'(0)) begin
      failures++;
      $display("[TB] FAIL fill_drained got=%0d want=0", vcCount[0 +: CW]);
    end
  endtask

  task automatic test_isolation();
    vcReady = 2'b00;
    for (int k = 0; k < 4; k++) begin
      flitValid = 2'b01;
      flit = FW'(8'h10 + k);
      clockCycle();
    end
    vcReady = 2'b10;
    for (int k = 0; k < 8; k++) begin
      flitValid = 2'b10;
      flit = FW'(8'h20 + k);
      clockCycle();
    end
    flitValid = 2'b00;
    for (int k = 0; k < 2; k++) clockCycle();
    checks++;
    if (vcFlit[0 +: FW] !== FW'(8'h10) || vcCount[0 +: CW] !== CW'(4)) begin
      failures++;
      $display("[TB] FAIL isolation_vc0 got=%h/%0d want=10/4", vcFlit[0 +: FW], vcCount[0 +: CW]);
    end
  endtask

  task automatic test_escape();
    vcReady = 2'b00;
    flitValid = 2'b01;
    flit = FW'(8'h55);
    for (int k = 0; k < 5; k++) clockCycle();
    flitValid = 2'b10;
    flit = FW'(8'hB1);
    clockCycle();
    flitValid = 2'b00;
    checks++;
    if (vcFlit[FW +: FW] !== FW'(8'hB1) || vcCount[CW +: CW] !== CW'(1) || vcCount[0 +: CW] !== CW'(4)) begin
      failures++;
      $display("[TB] FAIL escape got=%h/%0d/%0d want=b1/1/4", vcFlit[FW +: FW], vcCount[CW +: CW], vcCount[0 +: CW]);
    end
    clockCycle();
  endtask

  task automatic test_protocol_err();
    flitValid = 2'b11;
    flit = FW'(8'hCC);
    clockCycle();
    flitValid = 2'b00;
    clockCycle();
    checks++;
    if (vcCount !== {CW'(1), CW'(4)}) begin
      failures++;
      $display("[TB] FAIL protocol_no_push got=%h want=%h", vcCount, {CW'(1), CW'(4)});
    end
  endtask

  task automatic test_full_pop_and_wrap();
    vcReady = 2'b01;
    flitValid = 2'b01;
    flit = FW'(8'h66);
    clockCycle();
    flitValid = 2'b00;
    checks++;
    if (vcCount[0 +: CW] !== CW'(3) || flitReady[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL full_pop got=%0d/%0b want=3/1", vcCount[0 +: CW], flitReady[0]);
    end
    vcReady = 2'b11;
    for (int k = 0; k < 5; k++) clockCycle();
    vcReady = 2'b01;
    for (int k = 0; k < 10; k++) begin
      flitValid = 2'b01;
      flit = FW'(8'h70 + k);
      clockCycle();
    end
    flitValid = 2'b00;
    for (int k = 0; k < 3; k++) clockCycle();
    checks++;
    if (q0.size() != 0 || vcValid[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wrap_drain got=%0d/%0b want=0/0", q0.size(), vcValid[0]);
    end
  endtask

  task automatic test_mid_reset();
    vcReady = 2'b00;
    for (int k = 0; k < 2; k++) begin
      flitValid = 2'b10;
      flit = FW'(8'h90 + k);
      clockCycle();
    end
    flitValid = 2'b00;
    rst = 1'b1;
    clockCycle();
    rst = 1'b0;
    clockCycle();
    checks++;
    if (vcCount !== '0 || vcValid !== 2'b00) begin
      failures++;
      $display("[TB] FAIL mid_reset got=%h/%b want=0/00", vcCount, vcValid);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_isolation();
    test_escape();
    test_protocol_err();
    test_full_pop_and_wrap();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
